spike_rate_encoder: RTL and testbench

Upstream input stage of the spiking network. Holds one 8-bit intensity per input channel, written over the byte-wide load port. On `start` it produces a fixed-length train of spike vectors with a deterministic phase-accumulator rate code. Vectors are delivered to the multilayer core over a valid/ready handshake that supports stalls.

---
 rtl/snn_pkg.sv | 23 ++
 rtl/rate_accum.sv | 46 ++++
 rtl/spike_rate_encoder.sv | 168 ++++++++++++++++
 tb/tb_spike_rate_encoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Definitions shared by the spiking-network blocks. It holds the encoder FSM
// state type and the default network dimensions. The multilayer core uses the
// same dimensions, so the input stage and the core agree on vector width and
// presentation length.
// ---------------------------------------------------------------------------
package snn_pkg;

    // Default network dimensions
    localparam int SNN_N_INPUTS = 8;   // input channels (spike vector width)
    localparam int SNN_INT_W    = 8;   // intensity / accumulator width
    localparam int SNN_T_STEPS  = 16;  // time steps per presentation

    // Rate encoder control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } enc_state_t;

endpackage

// File: rtl/rate_accum.sv
// ---------------------------------------------------------------------------
// rate_accum
// Phase accumulator for one input channel. On each advance the channel
// intensity is added to the accumulator. The accumulator wraps, and the
// overflow of the (INT_W+1)-bit sum is the spike for that step. The carry
// output is combinational from the current accumulator and intensity, so the
// parent registers it in the same cycle as it asserts advance.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (accumulator to 0)
//   intensity  channel intensity (INT_W bits)
//   clear      zero the accumulator at the start of a presentation
//   advance    commit acc + intensity (wrapping)
//   carry      overflow of acc + intensity; this is the spike for this step
// ---------------------------------------------------------------------------
module rate_accum
    import snn_pkg::*;
#(
    parameter int INT_W = SNN_INT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INT_W-1:0] intensity,
    input  logic             clear,
    input  logic             advance,
    output logic             carry
);

    logic [INT_W-1:0] acc;
    logic [INT_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, intensity};
    assign carry = sum[INT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (advance) begin
            acc <= sum[INT_W-1:0];
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// ---------------------------------------------------------------------------
// spike_rate_encoder
// Input stage of the spiking network. It stores one intensity per channel.
// On start it emits T_STEPS spike vectors that use a phase-accumulator rate
// code: over a run, channel i fires floor(I*T_STEPS/2^INT_W) times. Vectors
// are sent over a valid/ready handshake, and the downstream can stall it.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   load_en      write intensity[load_addr] <= load_data (IDLE only)
//   load_addr    channel index; out-of-range indices are ignored
//   load_data    intensity value
//   start        begin a presentation (IDLE only)
//   abort        return to IDLE from any state
//   spike_valid  spikes/step_idx hold a valid vector
//   spike_ready  downstream accepts the vector
//   spikes       spike vector, bit i = channel i
//   step_idx     time step of the presented vector
//   busy         high in RUN and DRAIN
//   done         one-cycle pulse at the end of a presentation
// ---------------------------------------------------------------------------
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int  N_INPUTS = SNN_N_INPUTS,
    parameter int  INT_W    = SNN_INT_W,
    parameter int  T_STEPS  = SNN_T_STEPS,
    localparam int ADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int STEP_W   = $clog2(T_STEPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [INT_W-1:0]    load_data,
    input  logic                start,
    input  logic                abort,
    output logic                spike_valid,
    input  logic                spike_ready,
    output logic [N_INPUTS-1:0] spikes,
    output logic [STEP_W-1:0]   step_idx,
    output logic                busy,
    output logic                done
);

    enc_state_t          state;
    enc_state_t          state_next;

    logic [INT_W-1:0]    intensity [N_INPUTS];
    logic [STEP_W-1:0]   counter;
    logic [N_INPUTS-1:0] carry;

    logic                write_en;
    logic                start_run;
    logic                issue;
    logic                last_issue;

    // Loads are accepted in IDLE. abort only blocks start, because the
    // intensities are not touched by abort.
    assign write_en   = (state == IDLE) && load_en;
    assign start_run  = (state == IDLE) && start && !abort;

    // The output register is free when it is empty or its vector is being
    // taken in this cycle. That lets back-to-back vectors go out at full rate.
    assign issue      = (state == RUN) && !abort && (!spike_valid || spike_ready);
    assign last_issue = issue && (counter == STEP_W'(T_STEPS - 1));

    // ------------------------------------------------------------------
    // Per-channel phase accumulators
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_INPUTS; g++) begin : g_chan
        rate_accum #(
            .INT_W (INT_W)
        ) u_accum (
            .clk       (clk),
            .rst_n     (rst_n),
            .intensity (intensity[g]),
            .clear     (start_run),
            .advance   (issue),
            .carry     (carry[g])
        );
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and status outputs
    // busy and done decode the state register only. This keeps spike_ready
    // off every combinational path to an output.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;

        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)                      state_next = RUN;
                RUN:     if (last_issue)                 state_next = DRAIN;
                DRAIN:   if (spike_valid && spike_ready) state_next = DONE;
                DONE:                                    state_next = IDLE;
                default:                                 state_next = IDLE;
            endcase
        end

        case (state)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    // ------------------------------------------------------------------
    // Intensity registers
    // Any index that matches no channel writes nothing.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                intensity[i] <= '0;
            end
        end else if (write_en) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (load_addr == ADDR_W'(i)) begin
                    intensity[i] <= load_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Step counter and output register
    // The counter and accumulators are not cleared by abort. They are cleared
    // by the next start instead.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter     <= '0;
            spikes      <= '0;
            step_idx    <= '0;
            spike_valid <= 1'b0;
        end else if (abort) begin
            spike_valid <= 1'b0;
        end else if (start_run) begin
            counter     <= '0;
        end else if (issue) begin
            spikes      <= carry;
            step_idx    <= counter;
            spike_valid <= 1'b1;
            counter     <= counter + 1'b1;
        end else if (state == DRAIN && spike_valid && spike_ready) begin
            spike_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_encoder
// Scoreboard bench for spike_rate_encoder. Each start pushes the expected
// (step, spike vector) sequence into a queue. The expected sequence comes
// from the arithmetic rate rule: channel i fires on step t exactly when
// floor((t+1)*I/256) differs from floor(t*I/256).
// A negedge monitor pops and compares every accepted vector. It also checks
// that the vector is stable while stalled, and that done is a clean pulse.
// ---------------------------------------------------------------------------
module tb_spike_rate_encoder;

    localparam int N = 8;
    localparam int W = 8;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_en;
    logic [2:0]   load_addr;
    logic [W-1:0] load_data;
    logic         start;
    logic         abort;
    logic         spike_valid;
    logic         spike_ready;
    logic [N-1:0] spikes;
    logic [3:0]   step_idx;
    logic         busy;
    logic         done;

    spike_rate_encoder #(
        .N_INPUTS (N),
        .INT_W    (W),
        .T_STEPS  (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .abort       (abort),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spikes      (spikes),
        .step_idx    (step_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           step;
        logic [N-1:0] spk;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     model_int [N];
    int     got_tot [N];
    int     tot1 [N];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     start_cyc = 0;
    int     done_cyc  = 0;
    int     done_seen = 0;
    bit     stall_hold = 0;
    bit     prev_done  = 0;
    logic [N-1:0] held_spikes;
    logic [3:0]   held_step;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string name, input longint act, input longint expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Number of spikes a channel of intensity inten has emitted after `steps` steps
    function automatic int fire_count(input int inten, input int steps);
        return (inten * steps) / (1 << W);
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int t = 0; t < T; t++) begin
            e.step = t;
            for (int i = 0; i < N; i++)
                e.spk[i] = (fire_count(model_int[i], t + 1) != fire_count(model_int[i], t));
            exp_q.push_back(e);
        end
    endtask

    // Monitor: vectors are accepted at the posedge after a negedge that sees valid && ready
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_hold = 0;
            prev_done  = 0;
        end else begin
            if (stall_hold && spike_valid) begin
                check_eq("stall_spikes", spikes, held_spikes);
                check_eq("stall_step", step_idx, held_step);
            end
            if (spike_valid && spike_ready) begin
                check_eq("vector_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("step_idx", step_idx, mon_e.step);
                    check_eq("spikes", spikes, mon_e.spk);
                    for (int i = 0; i < N; i++) got_tot[i] += int'(spikes[i]);
                end
            end
            stall_hold  = spike_valid && !spike_ready;
            held_spikes = spikes;
            held_step   = step_idx;
            if (done) begin
                check_eq("done_busy_low", busy, 0);
                check_eq("done_one_cycle", prev_done, 0);
                done_seen++;
                done_cyc = cyc;
            end
            prev_done = done;
        end
    end

    task automatic do_load(input int a, input int d);
        @(posedge clk); #1;
        load_en = 1; load_addr = 3'(a); load_data = W'(d);
        model_int[a] = d;
        @(posedge clk); #1;
        load_en = 0;
    endtask

    // Start a run, optionally with a write in the same IDLE cycle
    task automatic do_start(input bit with_load, input int a, input int d);
        @(posedge clk); #1;
        start = 1;
        if (with_load) begin
            load_en = 1; load_addr = 3'(a); load_data = W'(d);
            model_int[a] = d;
        end
        for (int i = 0; i < N; i++) got_tot[i] = 0;
        push_expected();
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 0; load_en = 0;
        check_eq("start_busy", busy, 1);
        check_eq("start_no_valid_yet", spike_valid, 0);
    endtask

    // Drive spike_ready and mid-run events until done, abort or reset
    task automatic drive_run(input bit rnd, input int inj_step, input int abort_step,
                             input bit rst_drain, output bit finished);
        int d0 = done_seen;
        bit injected = 0;
        finished = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            load_en = 0; start = 0;
            if (done_seen != d0) begin
                finished = 1;
                break;
            end
            spike_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_step >= 0 && spike_valid && int'(step_idx) == abort_step) begin
                spike_ready = 0; abort = 1;
                @(posedge clk); #1;
                abort = 0;
                check_eq("abort_valid", spike_valid, 0);
                check_eq("abort_busy", busy, 0);
                exp_q.delete();
                return;
            end
            if (rst_drain && spike_valid && int'(step_idx) == T - 1) begin
                spike_ready = 0;
                check_eq("drain_busy", busy, 1);
                #2 rst_n = 0;
                #1;
                check_eq("rst_spikes", spikes, 0);
                check_eq("rst_step", step_idx, 0);
                check_eq("rst_valid", spike_valid, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_done", done, 0);
                exp_q.delete();
                for (int i = 0; i < N; i++) model_int[i] = 0;
                return;
            end
            if (inj_step >= 0 && !injected && spike_valid && int'(step_idx) == inj_step) begin
                load_en = 1; load_addr = 0; load_data = 0; start = 1;
                injected = 1;
            end
        end
        check_eq("done_within_budget", finished, 1);
    endtask

    task automatic full_run(input bit rnd, input int inj_step);
        bit fin;
        do_start(0, 0, 0);
        drive_run(rnd, inj_step, -1, 0, fin);
        if (fin) begin
            check_eq("queue_drained", exp_q.size(), 0);
            for (int i = 0; i < N; i++)
                check_eq($sformatf("total_ch%0d", i), got_tot[i], fire_count(model_int[i], T));
            if (!rnd) check_eq("done_latency", done_cyc + 1 - start_cyc, T + 2);
        end
    endtask

    initial begin
        bit fin;
        int d0;
        rst_n = 0; load_en = 0; load_addr = 0; load_data = 0;
        start = 0; abort = 0; spike_ready = 0;
        for (int i = 0; i < N; i++) model_int[i] = 0;

        // Reset state
        @(posedge clk); #1;
        check_eq("reset_spikes", spikes, 0);
        check_eq("reset_step", step_idx, 0);
        check_eq("reset_valid", spike_valid, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        @(negedge clk); rst_n = 1;

        // Reference pattern with ready held high
        do_load(0, 128); do_load(1, 64); do_load(2, 255); do_load(3, 0);
        full_run(0, -1);
        check_eq("ref_ch0", got_tot[0], 8);
        check_eq("ref_ch1", got_tot[1], 4);
        check_eq("ref_ch2", got_tot[2], 15);
        check_eq("ref_ch3", got_tot[3], 0);
        for (int i = 0; i < N; i++) tot1[i] = got_tot[i];

        // Same load with random back-pressure
        for (int r = 0; r < 3; r++) begin
            full_run(1, -1);
            for (int i = 0; i < N; i++)
                check_eq($sformatf("stall_total_ch%0d", i), got_tot[i], tot1[i]);
        end

        // load_en and start while running are ignored
        full_run(0, 5);
        full_run(0, -1);
        check_eq("ch0_kept", got_tot[0], 8);

        // Abort at step 7, then a clean restart
        d0 = done_seen;
        do_start(0, 0, 0);
        drive_run(0, -1, 7, 0, fin);
        repeat (20) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_seen, d0);
        full_run(0, -1);

        // Reset mid-DRAIN clears the intensities
        do_start(0, 0, 0);
        drive_run(0, -1, -1, 1, fin);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        full_run(0, -1);
        check_eq("post_reset_ch0", got_tot[0], 0);
        check_eq("post_reset_ch2", got_tot[2], 0);

        // Write and start in the same IDLE cycle
        do_start(1, 5, 200);
        drive_run(0, -1, -1, 0, fin);
        if (fin) begin
            check_eq("same_cycle_ch5", got_tot[5], 12);
            check_eq("same_cycle_queue", exp_q.size(), 0);
        end

        // Randomized intensities under random back-pressure
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) do_load(i, int'($urandom_range(0, 255)));
            full_run(1, -1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
